// File: rtl/minilab_pkg.sv
// -----------------------------------------------------------------------------
// minilab_pkg
// Shared types and constants for the Minilab matrix-load memory path.
//   word_t        : 64-bit data word (8 bytes)
//   addr_t        : 32-bit word address
//   resp_state_t  : responder FSM states (INIT, READY, FULL)
//   B_WORD_ADDR   : ROM word holding the B vector
//   A_WORD_BASE   : first ROM word holding an A row
//   NUM_A_ROWS    : number of A rows stored after the B vector
//   rom_pattern() : built-in ROM contents, byte k of word i = {i[3:0], k[3:0]}
// -----------------------------------------------------------------------------
package minilab_pkg;

    typedef logic [63:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        READY = 2'd1,
        FULL  = 2'd2
    } resp_state_t;

    localparam int unsigned B_WORD_ADDR = 0;
    localparam int unsigned A_WORD_BASE = 1;
    localparam int unsigned NUM_A_ROWS  = 8;

    function automatic word_t rom_pattern(input int unsigned index);
        word_t       w;
        logic [31:0] idx;
        logic [31:0] kk;
        w   = '0;
        idx = index;
        for (int k = 0; k < 8; k++) begin
            kk = k;
            w[k*8 +: 8] = {idx[3:0], kk[3:0]};
        end
        return w;
    endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// -----------------------------------------------------------------------------
// rd_latency_pipe
// Fixed-depth shift register that delays each accepted read by LATENCY clocks.
// Each stage carries {valid, addr_err, rom_index}; entries leave in the order
// they entered, so responses are inherently in order.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset, clears every stage
//   push_valid : a read is accepted this cycle
//   push_err   : the accepted address is outside the ROM
//   push_index : ROM word index of the accepted read
//   ret_valid  : last stage holds a read due for response
//   ret_err    : out-of-range flag of that read
//   ret_index  : ROM word index of that read
// -----------------------------------------------------------------------------
module rd_latency_pipe #(
    parameter int LATENCY = 3,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic             push_err,
    input  logic [IDX_W-1:0] push_index,
    output logic             ret_valid,
    output logic             ret_err,
    output logic [IDX_W-1:0] ret_index
);

    logic             valid_q [LATENCY];
    logic             err_q   [LATENCY];
    logic [IDX_W-1:0] index_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                err_q[i]   <= 1'b0;
                index_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push_valid;
            err_q[0]   <= push_err;
            index_q[0] <= push_index;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                index_q[i] <= index_q[i-1];
            end
        end
    end

    assign ret_valid = valid_q[LATENCY-1];
    assign ret_err   = err_q[LATENCY-1];
    assign ret_index = index_q[LATENCY-1];

endmodule

// File: rtl/avmm_rom_responder.sv
// -----------------------------------------------------------------------------
// avmm_rom_responder
// Avalon-MM pipelined read responder serving 64-bit words from an internal ROM
// (word 0 = B vector, words 1..8 = A rows) to the matrix-load read master.
// Fixed read latency, in-order responses, outstanding reads bounded through
// waitrequest.
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   address       : word address, valid while read=1
//   read          : read request
//   waitrequest   : 1 = request not accepted this cycle
//   readdata      : response data, holds its value between responses
//   readdatavalid : one-cycle strobe qualifying readdata
//   addr_err      : one-cycle strobe with readdatavalid for out-of-range reads
//   pending       : accepted-but-unreturned read count
// Build option:
//   STALL_INJECT_EN : adds an LFSR that randomly raises waitrequest in READY.
//
// Handshake: a read is accepted at a rising edge where read=1 and
// waitrequest=0; the master must hold read/address stable while waitrequest=1.
// Every accepted read produces exactly one readdatavalid pulse READ_LATENCY
// clocks after the accepting edge, in acceptance order; the master samples
// readdata/addr_err only when readdatavalid=1 (no backpressure on responses).
// -----------------------------------------------------------------------------
module avmm_rom_responder
    import minilab_pkg::*;
#(
    parameter int    ADDR_WIDTH   = 32,
    parameter int    DATA_WIDTH   = 64,
    parameter int    DEPTH        = 9,
    parameter int    READ_LATENCY = 3,
    parameter int    MAX_PENDING  = 4,
    parameter string INIT_FILE    = ""
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic                           read,
    output logic                           waitrequest,
    output logic [DATA_WIDTH-1:0]          readdata,
    output logic                           readdatavalid,
    output logic                           addr_err,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = $clog2(MAX_PENDING + 1);

    // ROM contents come from the built-in byte pattern.
    logic [DATA_WIDTH-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = DATA_WIDTH'(rom_pattern(g));
    end

    resp_state_t      state_q;
    resp_state_t      state_d;
    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] req_index;
    logic [PW-1:0]    pend_next;
    logic             wait_d;
    logic             p_valid;
    logic             p_err;
    logic [IDX_W-1:0] p_index;

    assign accept   = read & ~waitrequest;
    // Full-width compare: large addresses must not alias onto ROM words.
    assign in_range = (address < ADDR_WIDTH'(DEPTH));
    assign req_index = in_range ? address[IDX_W-1:0] : '0;

    // A retirement is the cycle readdatavalid is high; accept and retire in
    // the same cycle cancel out.
    assign pend_next = pending + PW'(accept) - PW'(readdatavalid);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    state_d = READY;
            READY:   if (pend_next == PW'(MAX_PENDING)) state_d = FULL;
            FULL:    if (readdatavalid) state_d = READY;
            default: state_d = INIT;
        endcase
    end

`ifdef STALL_INJECT_EN
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form.
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end

    // Uses the next LFSR value so the registered stall lines up with the
    // LFSR value visible during the stalled cycle.
    assign wait_d = (state_d != READY) || (lfsr_d[1:0] == 2'b00);
`else
    assign wait_d = (state_d != READY);
`endif

    // waitrequest is registered from the next state: no path from read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            waitrequest <= 1'b1;
            pending     <= '0;
        end else begin
            state_q     <= state_d;
            waitrequest <= wait_d;
            pending     <= pend_next;
        end
    end

    rd_latency_pipe #(
        .LATENCY (READ_LATENCY),
        .IDX_W   (IDX_W)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (accept),
        .push_err   (~in_range),
        .push_index (req_index),
        .ret_valid  (p_valid),
        .ret_err    (p_err),
        .ret_index  (p_index)
    );

    // Output register stage: the ROM lookup of the last pipe stage lands here,
    // giving READ_LATENCY clocks from the accepting edge to readdatavalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdatavalid <= 1'b0;
            addr_err      <= 1'b0;
            readdata      <= '0;
        end else begin
            readdatavalid <= p_valid;
            addr_err      <= p_valid & p_err;
            if (p_valid) readdata <= p_err ? '0 : rom[p_index];
        end
    end

endmodule

// File: tb/tb_avmm_rom_responder.sv
module tb_avmm_rom_responder;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 9;
  localparam int LAT   = 3;
  localparam int MAXP  = 4;
  localparam int PW    = $clog2(MAXP + 1);

  logic          clk;
  logic          rst;
  logic          read;
  logic [AW-1:0] address;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          addr_err;
  logic [PW-1:0] pending;

  avmm_rom_responder #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT),
    .MAX_PENDING  (MAXP),
    .INIT_FILE    ("")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .address       (address),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .addr_err      (addr_err),
    .pending       (pending)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int unsigned   tests = 0;
  int unsigned   fails = 0;
  logic [DW:0]   exp_q[$];   // {addr_err, readdata}
  int unsigned   due_q[$];   // edge number after which the response is visible
  int unsigned   edge_n = 0;
  int            m_pending = 0;
  bit            m_init = 0;
  bit            m_retire = 0;
  int            n_acc = 0;
  int            n_valid = 0;
  int            dut_peak = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ROM: byte k of word a is 16*(a mod 16)+k; outside the ROM -> 0.
  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    if (a >= DEPTH) return '0;
    for (int k = 0; k < DW/8; k++) w = w | (DW'((a % 16) * 16 + k) << (8 * k));
    return w;
  endfunction

  // Compare outputs (called at the falling edge) against the model.
  task automatic sample();
    bit          exp_v;
    bit          exp_w;
    logic [DW:0] e;
    exp_v = (due_q.size() > 0) && (due_q[0] == edge_n);
    chk("readdatavalid", readdatavalid, exp_v);
    if (exp_v) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      chk("readdata", readdata, e[DW-1:0]);
      chk("addr_err", addr_err, e[DW]);
      last_rdata = readdata;
      last_err   = addr_err;
      n_valid++;
    end else begin
      chk("addr_err_idle", addr_err, 0);
    end
    chk("pending", pending, m_pending);
    exp_w = m_init || (m_pending == MAXP);
`ifdef STALL_INJECT_EN
    if (exp_w) chk("waitrequest", waitrequest, 1);
`else
    chk("waitrequest", waitrequest, exp_w);
`endif
    if (int'(pending) > dut_peak) dut_peak = int'(pending);
    m_retire = exp_v;
  endtask

  // One clock: check, drive, advance the model across the rising edge.
  task automatic cycle(input logic rd, input logic [AW-1:0] a, output bit acc);
    sample();
    read    = rd;
    address = a;
    acc     = rd && (waitrequest === 1'b0);
    @(posedge clk);
    edge_n++;
    if (acc) begin
      due_q.push_back(edge_n + LAT);
      exp_q.push_back({(a >= DEPTH), ref_word(a)});
      n_acc++;
    end
    m_pending = m_pending + int'(acc) - int'(m_retire);
    m_retire  = 0;
    m_init    = 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle(1'b0, '0, acc);
  endtask

  // Hold the request until accepted, bounded.
  task automatic issue(input logic [AW-1:0] a);
    bit acc = 0;
    int guard = 0;
    while (!acc && guard < 64) begin
      cycle(1'b1, a, acc);
      guard++;
    end
    if (!acc) chk("issue_timeout", acc, 1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    read    = 1'b0;
    address = '0;
    exp_q.delete();
    due_q.delete();
    m_pending = 0;
    m_retire  = 0;
    #1;
    chk("rst_readdatavalid", readdatavalid, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_pending", pending, 0);
    chk("rst_waitrequest", waitrequest, 1);
    repeat (2) @(negedge clk);
    chk("rst_hold_readdatavalid", readdatavalid, 0);
    rst    = 1'b0;
    m_init = 1;
  endtask

  initial begin
    int          g;
    int          nv0;
    int          na0;
    logic [AW-1:0] ra;

    rst     = 1'b1;
    read    = 1'b0;
    address = '0;

    // reset release, single read of word 0
    do_reset();
    idle(1);
    issue(AW'(0));
    idle(LAT + 2);
    chk("t1_count", n_valid, 1);
    chk("t1_word0", last_rdata, 64'h0706050403020100);
    chk("t1_err", last_err, 0);

    // nine back-to-back reads with read held high
    dut_peak = 0;
    for (int i = 0; i < 9; i++) issue(AW'(i));
    idle(LAT + 3);
    chk("t2_count", n_valid, 10);
    chk("t2_word8", last_rdata, 64'h8786858483828180);
`ifndef STALL_INJECT_EN
    chk("t2_peak", dut_peak, MAXP);
`endif

    // out-of-range addresses
    issue(AW'(9));
    issue(32'hFFFF_FFFF);
    idle(LAT + 3);
    chk("t3_count", n_valid, 12);
    chk("t3_rdata", last_rdata, 0);
    chk("t3_err", last_err, 1);

    // accept and retire in the same cycle at pending=2
    issue(AW'(1));
    issue(AW'(2));
    g = 0;
    while (!((due_q.size() > 0) && (due_q[0] == edge_n)) && g < 16) begin
      idle(1);
      g++;
    end
    issue(AW'(3));
`ifndef STALL_INJECT_EN
    chk("t4_pending", pending, 2);
    chk("t4_waitrequest", waitrequest, 0);
`endif
    idle(LAT + 3);

    // reset with three reads in flight
    issue(AW'(4));
    issue(AW'(5));
    issue(AW'(6));
    do_reset();
    idle(LAT + 3);
    chk("t5_pending", pending, 0);
    chk("t5_waitrequest", waitrequest, 0);

    // randomized reads with gaps
    nv0 = n_valid;
    na0 = n_acc;
    for (int n = 0; n < 100; n++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) ra = AW'($urandom);
      else                           ra = AW'($urandom_range(0, DEPTH - 1));
      issue(ra);
    end
    idle(LAT + 3);
    chk("t6_accepted", n_acc - na0, 100);
    chk("t6_returned", n_valid - nv0, 100);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
